// File: rtl/myproject_div_pkg.sv
// Shared widths, state encoding and saturation limits for the sequential
// signed-by-unsigned divider.
package myproject_div_pkg;

  localparam int DIVIDEND_W = 26;
  localparam int DIVISOR_W  = 12;
  localparam int QUOT_W     = 16;
  localparam int REM_W      = 13;
  localparam int CNT_W      = 5;
  localparam int STEPS      = 26;

  localparam logic [QUOT_W-1:0] QMAX = 16'h7FFF;
  localparam logic [QUOT_W-1:0] QMIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/myproject_udiv_core.sv
// Unsigned 26/12 restoring divider iteration: one quotient bit per busy cycle,
// with its own step counter, partial remainder and quotient registers.
module myproject_udiv_core
  import myproject_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  busy_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  last_o,
  output logic [DIVIDEND_W-1:0] quo_o,
  output logic [REM_W-1:0]      rem_o
);

  logic [DIVIDEND_W-1:0] mag_q, mag_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // The partial remainder is always below the divisor, so 12 bits plus the
  // incoming dividend bit is all the trial subtraction ever needs.
  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] diff;
  logic             fits;

  assign shifted = {rem_q, mag_q[DIVIDEND_W-1]};
  assign fits    = (shifted >= {1'b0, div_q});
  assign diff    = shifted - {1'b0, div_q};

  always_comb begin
    mag_d = mag_q;
    quo_d = quo_q;
    div_d = div_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (start_i) begin
      mag_d = dividend_i;
      div_d = divisor_i;
      quo_d = '0;
      rem_d = '0;
      cnt_d = '0;
    end else if (busy_i) begin
      mag_d = {mag_q[DIVIDEND_W-2:0], 1'b0};
      quo_d = {quo_q[DIVIDEND_W-2:0], fits};
      rem_d = DIVISOR_W'(fits ? diff : shifted);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      mag_q <= mag_d;
      quo_q <= quo_d;
      div_q <= div_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = busy_i && (cnt_q == CNT_W'(STEPS - 1));
  assign quo_o  = quo_q;
  assign rem_o  = {1'b0, rem_q};

endmodule

// File: rtl/myproject_sdiv_26s_12ns_16_seq.sv
// Sequential signed/unsigned divider top: sign and magnitude handling,
// saturation, divide-by-zero and the ap_start/ap_done handshake.
module myproject_sdiv_26s_12ns_16_seq
  import myproject_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dz
);

  state_e state_q, state_d;
  logic   sign_q, sign_d;
  logic   zdiv_q, zdiv_d;
  logic   idle_q;
  logic   done_q, done_d;

  logic [QUOT_W-1:0] dout_q, dout_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic              dz_q, dz_d;

  logic                  core_start;
  logic                  core_busy;
  logic                  core_last;
  logic [DIVIDEND_W-1:0] quo_mag;
  logic [REM_W-1:0]      rem_mag;
  logic [DIVIDEND_W-1:0] din0_mag;

  // |-2^25| = 2^25 still fits because the magnitude is treated as unsigned.
  assign din0_mag = din0[din0_WIDTH-1] ? DIVIDEND_W'(-din0) : din0;
  assign ap_ready = ap_start && idle_q;

  myproject_udiv_core u_core (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .start_i    (core_start),
    .busy_i     (core_busy),
    .dividend_i (din0_mag),
    .divisor_i  (din1),
    .last_o     (core_last),
    .quo_o      (quo_mag),
    .rem_o      (rem_mag)
  );

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    zdiv_d     = zdiv_q;
    done_d     = 1'b0;
    dout_d     = dout_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    core_start = 1'b0;
    core_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          core_start = 1'b1;
          sign_d     = din0[din0_WIDTH-1];
          zdiv_d     = (din1 == '0);
          state_d    = (din1 == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        core_busy = 1'b1;
        if (core_last) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zdiv_q) begin
          dout_d = sign_q ? QMIN : QMAX;
          rem_d  = '0;
          ovf_d  = 1'b0;
          dz_d   = 1'b1;
        end else begin
          dz_d  = 1'b0;
          rem_d = sign_q ? (REM_W'(0) - rem_mag) : rem_mag;
          // Negative results may reach 32768 before saturating.
          if (!sign_q) begin
            ovf_d  = (quo_mag > DIVIDEND_W'(32767));
            dout_d = ovf_d ? QMAX : quo_mag[QUOT_W-1:0];
          end else begin
            ovf_d  = (quo_mag > DIVIDEND_W'(32768));
            dout_d = ovf_d ? QMIN : (QUOT_W'(0) - quo_mag[QUOT_W-1:0]);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      zdiv_q  <= zdiv_d;
      idle_q  <= (state_d == IDLE);
      done_q  <= done_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign ap_idle = idle_q;
  assign ap_done = done_q;
  assign dout    = dout_q;
  assign rem     = rem_q;
  assign ovf     = ovf_q;
  assign dz      = dz_q;

endmodule
